// File: rtl/prediction_pkg.sv
// Shared types and constants for the branch prediction resolver:
// predictor counter width default, resolver FSM states and statistics width.
package prediction_pkg;

    localparam int JSC_WIDTH_DEFAULT = 2;
    localparam int STAT_WIDTH        = 32;

    typedef enum logic {
        RES_IDLE  = 1'b0,
        RES_FLUSH = 1'b1
    } resolver_state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// Signal bundle between the pipeline front end and the branch resolver.
// The pipeline side uses the master modport, the resolver uses slave.
interface branch_resolver_if
    import prediction_pkg::*;
#(
    parameter int JUMP_STATUS_COUNTER_WIDTH = JSC_WIDTH_DEFAULT
) ();

    logic                                 PL_stall;
    logic                                 branch_if;
    logic [JUMP_STATUS_COUNTER_WIDTH-1:0] HP_count;
    logic                                 actual_taken_ex;

    logic                                 corrected_en;
    logic                                 corrected_result;
    logic                                 rollback_en_id;
    logic                                 rollback_en_ex;
    logic                                 flush_req;
    logic                                 pred_taken_ex;
    logic [STAT_WIDTH-1:0]                stat_branches;
    logic [STAT_WIDTH-1:0]                stat_mispredicts;

    modport master (
        output PL_stall, branch_if, HP_count, actual_taken_ex,
        input  corrected_en, corrected_result, rollback_en_id, rollback_en_ex,
        input  flush_req, pred_taken_ex, stat_branches, stat_mispredicts
    );

    modport slave (
        input  PL_stall, branch_if, HP_count, actual_taken_ex,
        output corrected_en, corrected_result, rollback_en_id, rollback_en_ex,
        output flush_req, pred_taken_ex, stat_branches, stat_mispredicts
    );

endinterface

// File: rtl/branch_resolver_sat_counter32.sv
// Saturating statistics counter: increments when enabled and sticks at
// all-ones instead of wrapping.
module sat_counter32
    import prediction_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [STAT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {STAT_WIDTH{1'b1}})) begin
            count <= count + STAT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Tracks speculative branch predictions from IF through EX, detects
// mispredicts, requests rollback/flush. Statistics: BRANCH_RESOLVER_STATS_EN.
module branch_resolver
    import prediction_pkg::*;
#(
    parameter int JUMP_STATUS_COUNTER_WIDTH = JSC_WIDTH_DEFAULT,
    parameter int FLUSH_CYCLES              = 1
) (
    input logic               clk,
    input logic               rst_n,
    branch_resolver_if.slave  bus
);

    localparam logic [0:0] ST_IDLE    = RES_IDLE;
    localparam logic [0:0] ST_FLUSH   = RES_FLUSH;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [0:0] state;
    logic [2:0] flush_cnt;
    logic       valid_id;
    logic       pred_id;
    logic       valid_ex;
    logic       pred_ex;
    logic       pred_if;
    logic       idle;
    logic       mispredict;
    logic       capture;
    logic       unused_hp;

    assign pred_if    = bus.HP_count[JUMP_STATUS_COUNTER_WIDTH-1];
    assign unused_hp  = ^bus.HP_count;
    assign idle       = (state == ST_IDLE);
    assign mispredict = valid_ex & ~bus.PL_stall & (pred_ex != bus.actual_taken_ex);
    assign capture    = bus.branch_if & idle & ~mispredict;

    // Outputs that depend on raw inputs are gated so everything reads 0 in reset
    assign bus.corrected_en     = rst_n & capture & ~bus.PL_stall;
    assign bus.corrected_result = rst_n & pred_if;
    assign bus.rollback_en_ex   = mispredict;
    assign bus.rollback_en_id   = mispredict & valid_id;
    assign bus.flush_req        = mispredict | ~idle;
    assign bus.pred_taken_ex    = pred_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_id <= 1'b0;
            pred_id  <= 1'b0;
            valid_ex <= 1'b0;
            pred_ex  <= 1'b0;
        end else if (!bus.PL_stall) begin
            valid_id <= capture;
            pred_id  <= pred_if;
            valid_ex <= valid_id & ~mispredict;
            pred_ex  <= pred_id;
        end
    end

    // A single-cycle flush never enters FLUSH; mispredict alone covers it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (mispredict) begin
                flush_cnt <= FLUSH_LOAD;
                if (FLUSH_LOAD != 3'd0) begin
                    state <= ST_FLUSH;
                end
            end
        end else begin
            flush_cnt <= flush_cnt - 3'd1;
            if (flush_cnt <= 3'd1) begin
                state <= ST_IDLE;
            end
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic branch_done;

    assign branch_done = ~bus.PL_stall & valid_ex;

    sat_counter32 u_stat_branches (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (branch_done),
        .count (bus.stat_branches)
    );

    sat_counter32 u_stat_mispredicts (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mispredict),
        .count (bus.stat_mispredicts)
    );
`else
    assign bus.stat_branches    = {STAT_WIDTH{1'b0}};
    assign bus.stat_mispredicts = {STAT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus a
// randomized run against a cycle-level reference model, on two flush lengths.
module tb_branch_resolver;

    localparam int W = 2;
`ifdef BRANCH_RESOLVER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [31:0] ONE = STATS ? 32'd1 : 32'd0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    branch_resolver_if #(.JUMP_STATUS_COUNTER_WIDTH(W)) bus1 ();
    branch_resolver_if #(.JUMP_STATUS_COUNTER_WIDTH(W)) bus3 ();

    branch_resolver #(.JUMP_STATUS_COUNTER_WIDTH(W), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    branch_resolver #(.JUMP_STATUS_COUNTER_WIDTH(W), .FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));

    task automatic drive(input logic stall, input logic br, input logic [W-1:0] hp, input logic act);
        bus1.PL_stall = stall; bus1.branch_if = br; bus1.HP_count = hp; bus1.actual_taken_ex = act;
        bus3.PL_stall = stall; bus3.branch_if = br; bus3.HP_count = hp; bus3.actual_taken_ex = act;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b1, 2'b11, 1'b1);
        n_checks++; if (bus1.corrected_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_corrected_en: got %b want 0", bus1.corrected_en); end
        n_checks++; if (bus1.corrected_result !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_corrected_result: got %b want 0", bus1.corrected_result); end
        n_checks++; if ({bus1.flush_req, bus1.rollback_en_ex, bus1.rollback_en_id, bus1.pred_taken_ex} !== 4'b0) begin n_fail++; $display("[TB] FAIL rst_outputs: got %b want 0000", {bus1.flush_req, bus1.rollback_en_ex, bus1.rollback_en_id, bus1.pred_taken_ex}); end
        @(posedge clk); #1;
        n_checks++; if ({bus1.stat_branches, bus1.stat_mispredicts} !== 64'd0) begin n_fail++; $display("[TB] FAIL rst_stats: got %h want 0", {bus1.stat_branches, bus1.stat_mispredicts}); end
        n_checks++; if (dut1.valid_id !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid_id: got %b want 0", dut1.valid_id); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        n_checks++; if (bus1.corrected_en !== 1'b1) begin n_fail++; $display("[TB] FAIL first_branch_en: got %b want 1", bus1.corrected_en); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b1);
        n_checks++; if (bus1.pred_taken_ex !== 1'b1) begin n_fail++; $display("[TB] FAIL first_branch_ex: got %b want 1", bus1.pred_taken_ex); end
        @(negedge clk);
    endtask

    task automatic test_correct_prediction();
        do_reset();
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        n_checks++; if (bus1.corrected_en !== 1'b1) begin n_fail++; $display("[TB] FAIL ok_corrected_en: got %b want 1", bus1.corrected_en); end
        n_checks++; if (bus1.corrected_result !== 1'b1) begin n_fail++; $display("[TB] FAIL ok_corrected_result: got %b want 1", bus1.corrected_result); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b1);
        n_checks++; if ({bus1.rollback_en_ex, bus1.rollback_en_id, bus1.flush_req} !== 3'b000) begin n_fail++; $display("[TB] FAIL ok_no_rollback: got %b want 000", {bus1.rollback_en_ex, bus1.rollback_en_id, bus1.flush_req}); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        n_checks++; if (bus1.stat_branches !== ONE) begin n_fail++; $display("[TB] FAIL ok_stat_branches: got %0d want %0d", bus1.stat_branches, ONE); end
        n_checks++; if (bus1.stat_mispredicts !== 32'd0) begin n_fail++; $display("[TB] FAIL ok_stat_mispredicts: got %0d want 0", bus1.stat_mispredicts); end
        @(negedge clk);
    endtask

    task automatic test_mispredict_with_id();
        do_reset();
        drive(1'b0, 1'b1, 2'b01, 1'b0);
        n_checks++; if ({bus1.corrected_en, bus1.corrected_result} !== 2'b10) begin n_fail++; $display("[TB] FAIL mp_first_push: got %b want 10", {bus1.corrected_en, bus1.corrected_result}); end
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b01, 1'b0);
        n_checks++; if (bus1.corrected_en !== 1'b1) begin n_fail++; $display("[TB] FAIL mp_second_push: got %b want 1", bus1.corrected_en); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b1);
        n_checks++; if ({bus1.rollback_en_ex, bus1.rollback_en_id, bus1.flush_req} !== 3'b111) begin n_fail++; $display("[TB] FAIL mp_rollback_both: got %b want 111", {bus1.rollback_en_ex, bus1.rollback_en_id, bus1.flush_req}); end
        @(posedge clk); #1;
        n_checks++; if ({dut1.valid_id, dut1.valid_ex} !== 2'b00) begin n_fail++; $display("[TB] FAIL mp_valid_cleared: got %b want 00", {dut1.valid_id, dut1.valid_ex}); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b1);
        n_checks++; if ({bus1.flush_req, bus1.rollback_en_ex} !== 2'b00) begin n_fail++; $display("[TB] FAIL mp_flush_one_cycle: got %b want 00", {bus1.flush_req, bus1.rollback_en_ex}); end
        n_checks++; if (bus1.stat_mispredicts !== ONE) begin n_fail++; $display("[TB] FAIL mp_stat_mispredicts: got %0d want %0d", bus1.stat_mispredicts, ONE); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(1'b0, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'b11, 1'b1);
        n_checks++; if ({bus1.corrected_en, bus1.rollback_en_ex, bus1.flush_req} !== 3'b011) begin n_fail++; $display("[TB] FAIL sim_no_push: got %b want 011", {bus1.corrected_en, bus1.rollback_en_ex, bus1.flush_req}); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        n_checks++; if ({bus1.rollback_en_ex, bus1.flush_req} !== 2'b00) begin n_fail++; $display("[TB] FAIL sim_never_in_ex: got %b want 00", {bus1.rollback_en_ex, bus1.flush_req}); end
        n_checks++; if (bus1.stat_branches !== ONE) begin n_fail++; $display("[TB] FAIL sim_stat_branches: got %0d want %0d", bus1.stat_branches, ONE); end
        @(negedge clk);
    endtask

    task automatic test_flush3();
        do_reset();
        drive(1'b0, 1'b1, 2'b10, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        // Flush cycle 3 has a stall: the flush counter must keep running
        for (int c = 0; c < 3; c++) begin
            drive((c == 2), 1'b1, 2'b00, (c != 0) ? 1'b1 : 1'b0);
            n_checks++; if ({bus3.flush_req, bus3.corrected_en} !== 2'b10) begin n_fail++; $display("[TB] FAIL f3_flush_c%0d: got %b want 10", c, {bus3.flush_req, bus3.corrected_en}); end
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 2'b00, 1'b1);
            n_checks++; if ({bus3.flush_req, bus3.rollback_en_ex} !== 2'b00) begin n_fail++; $display("[TB] FAIL f3_after_c%0d: got %b want 00", c, {bus3.flush_req, bus3.rollback_en_ex}); end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b0, 1'b1, 2'b11, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        n_checks++; if ({bus1.rollback_en_ex, bus1.flush_req, bus1.corrected_en} !== 3'b000) begin n_fail++; $display("[TB] FAIL st_no_mispredict: got %b want 000", {bus1.rollback_en_ex, bus1.flush_req, bus1.corrected_en}); end
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 1'b0);
        n_checks++; if (bus1.stat_branches !== 32'd0) begin n_fail++; $display("[TB] FAIL st_no_count: got %0d want 0", bus1.stat_branches); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        n_checks++; if ({bus1.rollback_en_ex, bus1.flush_req} !== 2'b11) begin n_fail++; $display("[TB] FAIL st_release_fires: got %b want 11", {bus1.rollback_en_ex, bus1.flush_req}); end
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        n_checks++; if (bus1.rollback_en_ex !== 1'b0) begin n_fail++; $display("[TB] FAIL st_fires_once: got %b want 0", bus1.rollback_en_ex); end
        n_checks++; if ({bus1.stat_branches, bus1.stat_mispredicts} !== {ONE, ONE}) begin n_fail++; $display("[TB] FAIL st_stats: got %h want %h", {bus1.stat_branches, bus1.stat_mispredicts}, {ONE, ONE}); end
        @(negedge clk);
    endtask

    task automatic test_saturation_reset();
        do_reset();
`ifdef BRANCH_RESOLVER_STATS_EN
        force dut1.u_stat_mispredicts.count = 32'hFFFF_FFFF;
        #1;
        release dut1.u_stat_mispredicts.count;
`endif
        drive(1'b0, 1'b1, 2'b01, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        n_checks++; if (bus1.stat_mispredicts !== (STATS ? 32'hFFFF_FFFF : 32'd0)) begin n_fail++; $display("[TB] FAIL sat_mispredicts: got %h want %h", bus1.stat_mispredicts, (STATS ? 32'hFFFF_FFFF : 32'd0)); end
        n_checks++; if (bus3.flush_req !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_in_flush: got %b want 1", bus3.flush_req); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus3.flush_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_abort_flush: got %b want 0", bus3.flush_req); end
        n_checks++; if ({bus3.stat_branches, bus3.stat_mispredicts, bus1.stat_mispredicts} !== 96'd0) begin n_fail++; $display("[TB] FAIL rst_clears_stats: got %h want 0", {bus3.stat_branches, bus3.stat_mispredicts, bus1.stat_mispredicts}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int          m_id[2], m_ex[2], m_fl[2];
        longint      m_nb[2], m_nm[2];
        int          fcyc[2];
        logic        stall, br, act, pt, mis, e_ce, e_fl, e_rid;
        logic [W-1:0] hp;
        logic        o_ce[2], o_cr[2], o_rex[2], o_rid[2], o_fl[2], o_pte[2];
        logic [31:0] o_nb[2], o_nm[2], e_nb, e_nm;

        fcyc[0] = 1; fcyc[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_id[k] = -1; m_ex[k] = -1; m_fl[k] = 0; m_nb[k] = 0; m_nm[k] = 0;
        end
        do_reset();
        for (int c = 0; c < 600; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            br    = 1'($urandom_range(0, 1));
            hp    = W'($urandom_range(0, 3));
            act   = 1'($urandom_range(0, 1));
            drive(stall, br, hp, act);
            o_ce[0] = bus1.corrected_en; o_cr[0] = bus1.corrected_result; o_rex[0] = bus1.rollback_en_ex;
            o_rid[0] = bus1.rollback_en_id; o_fl[0] = bus1.flush_req; o_pte[0] = bus1.pred_taken_ex;
            o_nb[0] = bus1.stat_branches; o_nm[0] = bus1.stat_mispredicts;
            o_ce[1] = bus3.corrected_en; o_cr[1] = bus3.corrected_result; o_rex[1] = bus3.rollback_en_ex;
            o_rid[1] = bus3.rollback_en_id; o_fl[1] = bus3.flush_req; o_pte[1] = bus3.pred_taken_ex;
            o_nb[1] = bus3.stat_branches; o_nm[1] = bus3.stat_mispredicts;
            for (int k = 0; k < 2; k++) begin
                // A counter in the upper half of its range means "predict taken"
                pt    = (int'(hp) >= 2);
                mis   = (m_ex[k] >= 0) && !stall && (m_ex[k] != int'(act));
                e_ce  = br && !stall && !mis && (m_fl[k] == 0);
                e_fl  = mis || (m_fl[k] > 0);
                e_rid = mis && (m_id[k] >= 0);
                e_nb  = STATS ? 32'(m_nb[k]) : 32'd0;
                e_nm  = STATS ? 32'(m_nm[k]) : 32'd0;
                n_checks++; if (o_ce[k] !== e_ce) begin n_fail++; $display("[TB] FAIL rnd%0d_corrected_en c%0d: got %b want %b", k, c, o_ce[k], e_ce); end
                n_checks++; if (o_cr[k] !== pt) begin n_fail++; $display("[TB] FAIL rnd%0d_corrected_result c%0d: got %b want %b", k, c, o_cr[k], pt); end
                n_checks++; if (o_rex[k] !== mis) begin n_fail++; $display("[TB] FAIL rnd%0d_rollback_ex c%0d: got %b want %b", k, c, o_rex[k], mis); end
                n_checks++; if (o_rid[k] !== e_rid) begin n_fail++; $display("[TB] FAIL rnd%0d_rollback_id c%0d: got %b want %b", k, c, o_rid[k], e_rid); end
                n_checks++; if (o_fl[k] !== e_fl) begin n_fail++; $display("[TB] FAIL rnd%0d_flush c%0d: got %b want %b", k, c, o_fl[k], e_fl); end
                if (m_ex[k] >= 0) begin
                    n_checks++; if (o_pte[k] !== (m_ex[k] == 1)) begin n_fail++; $display("[TB] FAIL rnd%0d_pred_ex c%0d: got %b want %b", k, c, o_pte[k], (m_ex[k] == 1)); end
                end
                n_checks++; if (o_nb[k] !== e_nb) begin n_fail++; $display("[TB] FAIL rnd%0d_stat_branches c%0d: got %0d want %0d", k, c, o_nb[k], e_nb); end
                n_checks++; if (o_nm[k] !== e_nm) begin n_fail++; $display("[TB] FAIL rnd%0d_stat_mispredicts c%0d: got %0d want %0d", k, c, o_nm[k], e_nm); end
                if (!stall && m_ex[k] >= 0) begin
                    if (m_nb[k] < 64'hFFFF_FFFF) m_nb[k]++;
                    if (mis && m_nm[k] < 64'hFFFF_FFFF) m_nm[k]++;
                end
                if (m_fl[k] > 0) m_fl[k]--;
                else if (mis) m_fl[k] = fcyc[k] - 1;
                if (!stall) begin
                    m_ex[k] = mis ? -1 : m_id[k];
                    m_id[k] = e_ce ? int'(pt) : -1;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        test_reset();
        test_correct_prediction();
        test_mispredict_with_id();
        test_simultaneous();
        test_flush3();
        test_stall();
        test_saturation_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
